// File: rtl/uart_tx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_pkg
// Shared UART definitions: frame state encoding, data width, minimum baud
// divisor and the parity helper. Intended to be shared with a future receive
// sequencer so both ends agree on state names and parity rules.
// ---------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity bit to transmit for a byte: even parity makes the total number of
  // ones (data + parity) even, odd parity makes it odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for a single asynchronous level. Output
// follows the input with two clock cycles of latency. Both flops load
// RESET_VAL under the synchronous reset.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   d     in  asynchronous input level
//   q     out synchronised level
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next-state for the two synchroniser stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit sequencer. Drains a lookahead byte FIFO (read data valid
// while not empty), one byte per frame, and serialises it LSB-first on tx:
// start bit, 8 data bits, optional parity, one or two stop bits. Divisor and
// frame format are sampled at the moment a byte is popped and held for the
// whole frame. Back-to-back frames run with no idle gap.
// Ports:
//   clk              in  system clock
//   reset            in  synchronous, active-high reset
//   enable           in  1 = allowed to start new frames
//   baud_div         in  clk cycles per bit (0/1 behave as 2)
//   parity_en        in  1 = insert parity bit after data
//   parity_odd       in  1 = odd parity, 0 = even
//   two_stop         in  1 = two stop bits, 0 = one
//   cts_n            in  asynchronous clear-to-send, active-low
//   fifo_not_empty   in  FIFO holds a byte
//   fifo_read_data   in  byte at FIFO head
//   fifo_read_enable out pop strobe (combinational), one cycle per byte
//   tx               out serial output, idle high (registered)
//   busy             out frame in progress (registered)
// ---------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 cts_n,
  input  logic                 fifo_not_empty,
  input  logic [7:0]           fifo_read_data,
  output logic                 fifo_read_enable,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [2:0]           IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_e            state_q,    state_d;
  logic [DIV_WIDTH-1:0] div_q,      div_d;
  logic [DIV_WIDTH-1:0] bit_cnt_q,  bit_cnt_d;
  logic [2:0]           idx_q,      idx_d;
  logic [7:0]           shift_q,    shift_d;
  logic                 par_bit_q,  par_bit_d;
  logic                 par_en_q,   par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;

  logic                 cts_sync_s;
  logic [DIV_WIDTH-1:0] eff_div_s;
  logic                 start_ok_s;
  logic                 bit_done_s;
  logic                 last_stop_s;
  logic                 pop_s;

  // cts_n resets to "not clear" so nothing leaves until the pin has been
  // seen low for two full cycles.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_cts_sync (
    .clk  (clk),
    .reset(reset),
    .d    (cts_n),
    .q    (cts_sync_s)
  );

  // Frame-start qualification and the shared pop strobe. A pop is only
  // possible from IDLE or in the last cycle of the final stop bit, so at
  // most one byte is taken per frame.
  always_comb begin
    eff_div_s   = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
    start_ok_s  = enable & fifo_not_empty & ~cts_sync_s;
    bit_done_s  = (bit_cnt_q == DIV_ZERO);
    last_stop_s = ~two_stop_q | stop_idx_q;
    pop_s       = ~reset & start_ok_s &
                  ((state_q == ST_IDLE) |
                   ((state_q == ST_STOP) & bit_done_s & last_stop_s));
  end

  assign fifo_read_enable = pop_s;

  // Frame sequencer: bit timing, data shifting, parity and stop handling.
  // tx_d always carries the level of the bit that starts on the next edge,
  // so the registered tx changes exactly on bit boundaries.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end

      ST_START: begin
        if (bit_done_s) begin
          state_d   = ST_DATA;
          idx_d     = 3'd0;
          bit_cnt_d = div_q - DIV_ONE;
          tx_d      = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q - DIV_ONE;
        end
      end

      ST_DATA: begin
        if (bit_done_s) begin
          bit_cnt_d = div_q - DIV_ONE;
          if (idx_q == IDX_LAST) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            // Next data bit is the one that lands in bit 0 after the shift.
            tx_d    = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - DIV_ONE;
        end
      end

      ST_PARITY: begin
        if (bit_done_s) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          bit_cnt_d  = div_q - DIV_ONE;
          tx_d       = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q - DIV_ONE;
        end
      end

      ST_STOP: begin
        if (bit_done_s) begin
          if (last_stop_s) begin
            // May be overridden below by a back-to-back pop.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
            bit_cnt_d  = div_q - DIV_ONE;
            tx_d       = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - DIV_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    // Pop edge: capture the head byte and freeze the frame configuration.
    if (pop_s) begin
      state_d    = ST_START;
      shift_d    = fifo_read_data;
      par_bit_d  = parity_bit(fifo_read_data, parity_odd);
      par_en_d   = parity_en;
      two_stop_d = two_stop;
      div_d      = eff_div_s;
      bit_cnt_d  = eff_div_s - DIV_ONE;
      idx_d      = 3'd0;
      stop_idx_d = 1'b0;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_ZERO;
      bit_cnt_q  <= DIV_ZERO;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        cts_n;
  logic        fifo_not_empty;
  logic [7:0]  fifo_read_data;
  logic        fifo_read_enable;
  logic        tx;
  logic        busy;

  uart_tx_ctrl #(.DIV_WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .baud_div        (baud_div),
    .parity_en       (parity_en),
    .parity_odd      (parity_odd),
    .two_stop        (two_stop),
    .cts_n           (cts_n),
    .fifo_not_empty  (fifo_not_empty),
    .fifo_read_data  (fifo_read_data),
    .fifo_read_enable(fifo_read_enable),
    .tx              (tx),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         n;
    logic       par;
    logic       odd;
    logic       two;
  } exp_t;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  int         pop_cyc[$];

  int   n_cmp, n_bad;
  int   cyc, pop_cnt, busy_cnt, busy_fall;
  logic busy_prev;
  int   mon_idx, mon_c;
  logic mon_active;
  exp_t mon_e;

  function automatic logic exp_bit(input exp_t e, input int c);
    int bi;
    bi = c / e.n;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return e.b[bi-1];
    if (e.par && bi == 9) return (^e.b) ^ e.odd;
    return 1'b1;
  endfunction

  function automatic int frame_len(input exp_t e);
    return e.n * (10 + int'(e.par) + int'(e.two));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic upd_fifo();
    fifo_not_empty = (fifo_q.size() != 0);
    fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    upd_fifo();
  endtask

  // One clock cycle: sample the pop strobe before the edge, model the FIFO
  // pop after it, then check the serial line at the following negedge.
  task automatic step();
    logic rd;
    exp_t e;
    #1;
    rd = fifo_read_enable;
    if (rd === 1'b1) begin
      chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      pop_cnt++;
      pop_cyc.push_back(cyc + 1);
      if (fifo_q.size() != 0) begin
        e.b   = fifo_q[0];
        e.n   = (baud_div < 16'd2) ? 2 : int'(baud_div);
        e.par = parity_en;
        e.odd = parity_odd;
        e.two = two_stop;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rd === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd_fifo();
    @(negedge clk);
    busy_cnt += int'(busy === 1'b1);
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall++;
    busy_prev = busy;
    if (reset === 1'b1) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      mon_c++;
      chk($sformatf("tx_bit[b%0h c%0d]", mon_e.b, mon_c), 32'(tx), 32'(exp_bit(mon_e, mon_c)));
      if (mon_c >= frame_len(mon_e) - 1) mon_active = 1'b0;
    end else if (tx === 1'b0) begin
      chk("start_expected", 32'(mon_idx < exp_q.size()), 32'd1);
      if (mon_idx < exp_q.size()) begin
        mon_e      = exp_q[mon_idx];
        mon_idx++;
        mon_c      = 0;
        mon_active = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pop(input int budget);
    int base;
    base = pop_cnt;
    for (int i = 0; i < budget && pop_cnt == base; i++) step();
    chk("pop_seen", 32'(pop_cnt > base), 32'd1);
  endtask

  int p0;
  int c0;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; pop_cnt = 0; busy_cnt = 0; busy_fall = 0;
    busy_prev = 1'b0; mon_idx = 0; mon_c = 0; mon_active = 1'b0;
    reset = 1'b1; enable = 1'b1; baud_div = 16'd4; parity_en = 1'b0;
    parity_odd = 1'b0; two_stop = 1'b0; cts_n = 1'b0;
    upd_fifo();

    // Reset state
    run(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(fifo_read_enable), 32'd0);
    reset = 1'b0;
    run(4);

    // 1: baud 4, 8N1, 0x55
    p0 = pop_cnt; busy_cnt = 0;
    push(8'h55);
    run(60);
    chk("t1_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd40);
    chk("t1_tx_idle", 32'(tx), 32'd1);

    // 2: baud 3, odd parity, two stop, 0x07
    baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
    p0 = pop_cnt; busy_cnt = 0;
    push(8'h07);
    run(60);
    chk("t2_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd36);

    // 3: back-to-back at baud 2
    baud_div = 16'd2; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    p0 = pop_cnt; busy_cnt = 0; busy_fall = 0;
    push(8'hA1); push(8'hB2); push(8'hC3);
    run(80);
    chk("t3_pops", 32'(pop_cnt - p0), 32'd3);
    chk("t3_gap1", 32'(pop_cyc[p0+1] - pop_cyc[p0]), 32'd20);
    chk("t3_gap2", 32'(pop_cyc[p0+2] - pop_cyc[p0+1]), 32'd20);
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd60);
    chk("t3_busy_falls", 32'(busy_fall), 32'd1);

    // 4: flow control through cts_n
    baud_div = 16'd4;
    cts_n = 1'b1;
    run(4);
    p0 = pop_cnt;
    push(8'h81); push(8'h42);
    run(10);
    chk("t4_no_pop_cts", 32'(pop_cnt - p0), 32'd0);
    chk("t4_tx_idle", 32'(tx), 32'd1);
    cts_n = 1'b0;
    c0 = cyc;
    run(6);
    chk("t4_pop_after_cts", 32'(pop_cnt - p0), 32'd1);
    chk("t4_cts_latency", 32'(pop_cyc[p0] - c0), 32'd3);
    run(7);
    cts_n = 1'b1;
    run(50);
    chk("t4_single_pop", 32'(pop_cnt - p0), 32'd1);
    chk("t4_fifo_left", 32'(fifo_q.size()), 32'd1);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // 5: divisor 0 and 1 behave as 2; mid-frame divisor change ignored
    baud_div = 16'd0; cts_n = 1'b0;
    p0 = pop_cnt; busy_cnt = 0;
    run(30);
    chk("t5_div0_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t5_div0_busy", 32'(busy_cnt), 32'd20);
    baud_div = 16'd1;
    p0 = pop_cnt; busy_cnt = 0;
    push(8'h3C);
    run(30);
    chk("t5_div1_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t5_div1_busy", 32'(busy_cnt), 32'd20);
    baud_div = 16'd5;
    p0 = pop_cnt; busy_cnt = 0;
    push(8'h96);
    wait_pop(20);
    run(5);
    baud_div = 16'd2;
    run(60);
    chk("t5_midchg_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t5_midchg_busy", 32'(busy_cnt), 32'd50);

    // 6: reset during data bit 3
    baud_div = 16'd4;
    p0 = pop_cnt;
    push(8'hE7); push(8'h18);
    wait_pop(20);
    run(17);
    reset = 1'b1;
    step();
    chk("t6_rst_tx", 32'(tx), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rd_en", 32'(fifo_read_enable), 32'd0);
    chk("t6_fifo_kept", 32'(fifo_q.size()), 32'd1);
    run(1);
    reset = 1'b0;
    run(80);
    chk("t6_pops", 32'(pop_cnt - p0), 32'd2);
    chk("t6_fifo_drained", 32'(fifo_q.size()), 32'd0);
    chk("t6_busy_end", 32'(busy), 32'd0);
    chk("frames_seen", 32'(mon_idx), 32'(exp_q.size()));
    chk("monitor_idle", 32'(mon_active), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
